lsu: RTL and testbench

Load/store unit of the hxd32 core. It consumes the execute unit's ALU result as the effective address and rs2 read data as store data. It drives a req/gnt/rvalid data-RAM bus and returns aligned, extended load data for writeback. It stalls the pipeline for the duration of each access.

---
 rtl/lsu_if.sv | 23 ++
 rtl/lsu.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-RAM req/gnt/rvalid bus between the load/store unit and memory
interface lsu_if #(
  parameter int XLEN = 32
);
  logic              dram_req_o;
  logic              dram_we_o;
  logic [XLEN-1:0]   dram_addr_o;
  logic [XLEN/8-1:0] dram_be_o;
  logic [XLEN-1:0]   dram_wr_data_o;
  logic              dram_gnt_i;
  logic              dram_rvalid_i;
  logic [XLEN-1:0]   dram_rd_data_i;

  modport master (
    output dram_req_o, dram_we_o, dram_addr_o, dram_be_o, dram_wr_data_o,
    input  dram_gnt_i, dram_rvalid_i, dram_rd_data_i
  );

  modport slave (
    input  dram_req_o, dram_we_o, dram_addr_o, dram_be_o, dram_wr_data_o,
    output dram_gnt_i, dram_rvalid_i, dram_rd_data_i
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - hxd32 load/store unit; optional bus-wait timeout under LSU_TIMEOUT_EN
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            lsu_rd_en_i,
  input  logic            lsu_wr_en_i,
  input  logic [2:0]      lsu_sel_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] rs2_rd_data_i,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic            lsu_err_o,
  output logic [XLEN-1:0] lsu_rd_data_o,
  lsu_if.master           dram
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_n;

  logic              r_req;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN/8-1:0] r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [2:0]        r_sel;
  logic [1:0]        r_off;
  logic [XLEN-1:0]   r_rd_data;
  logic              r_done;
  logic              r_err;

  logic              w_access;
  logic              w_store;
  logic              w_legal;
  logic              w_misal;
  logic              w_launch;
  logic              w_fault;
  logic              w_req_drop;
  logic              w_load_done;
  logic              w_timeout;
  logic [XLEN/8-1:0] w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_ext;

  // A simultaneous read and write request is handled as a store
  assign w_access = lsu_rd_en_i | lsu_wr_en_i;
  assign w_store  = lsu_wr_en_i;

  // Classify the presented instruction: funct3 legal for its direction, natural alignment
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    if (w_store) begin
      w_legal = (lsu_sel_i == 3'b000) || (lsu_sel_i == 3'b001) || (lsu_sel_i == 3'b010);
    end else begin
      w_legal = (lsu_sel_i[1:0] != 2'b11) && (lsu_sel_i != 3'b110);
    end
    case (lsu_sel_i[1:0])
      2'b01:   w_misal = alu_data_i[0];
      2'b10:   w_misal = |alu_data_i[1:0];
      default: w_misal = 1'b0;
    endcase
  end

  // Store byte lanes and lane-replicated write data; loads always read the full word
  always_comb begin
    w_be    = '1;
    w_wdata = rs2_rd_data_i;
    if (w_store) begin
      case (lsu_sel_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << alu_data_i[1:0];
          w_wdata = {4{rs2_rd_data_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << alu_data_i[1:0];
          w_wdata = {2{rs2_rd_data_i[15:0]}};
        end
        default: begin
          w_be    = '1;
          w_wdata = rs2_rd_data_i;
        end
      endcase
    end
  end

  assign w_shift = dram.dram_rd_data_i >> {r_off, 3'b000};

  // Align the addressed byte/half to bit 0 and extend according to the latched funct3
  always_comb begin
    case (r_sel)
      3'b000:  w_ext = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      3'b001:  w_ext = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Count cycles spent waiting on the bus; cleared as each request is launched
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_launch) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state plus single-cycle launch / drop / completion strobes
  always_comb begin
    w_state_n   = r_state;
    w_launch    = 1'b0;
    w_fault     = 1'b0;
    w_req_drop  = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (!w_legal || w_misal) begin
            w_fault   = 1'b1;
            w_state_n = S_DONE;
          end else begin
            w_launch  = 1'b1;
            w_state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dram.dram_gnt_i) begin
          w_req_drop = 1'b1;
          w_state_n  = r_we ? S_DONE : S_WAIT;
        end else if (w_timeout) begin
          w_req_drop = 1'b1;
          w_fault    = 1'b1;
          w_state_n  = S_DONE;
        end
      end
      S_WAIT: begin
        if (dram.dram_rvalid_i) begin
          w_load_done = 1'b1;
          w_state_n   = S_DONE;
        end else if (w_timeout) begin
          w_fault   = 1'b1;
          w_state_n = S_DONE;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Registered bus outputs, completion pulses and the held load result
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_sel     <= '0;
      r_off     <= '0;
      r_rd_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= (w_state_n == S_DONE);
      r_err  <= w_fault;
      if (w_launch) begin
        r_req   <= 1'b1;
        r_we    <= w_store;
        r_addr  <= {alu_data_i[XLEN-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_sel   <= lsu_sel_i;
        r_off   <= alu_data_i[1:0];
      end else if (w_req_drop) begin
        r_req <= 1'b0;
      end
      if (w_load_done) begin
        r_rd_data <= w_ext;
      end
    end
  end

  assign lsu_stall_o = (r_state == S_REQ) || (r_state == S_WAIT) ||
                       ((r_state == S_IDLE) && w_access);
  assign lsu_done_o    = r_done;
  assign lsu_err_o     = r_err;
  assign lsu_rd_data_o = r_rd_data;

  assign dram.dram_req_o     = r_req;
  assign dram.dram_we_o      = r_we;
  assign dram.dram_addr_o    = r_addr;
  assign dram.dram_be_o      = r_be;
  assign dram.dram_wr_data_o = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu (covers LSU_TIMEOUT_EN when defined)
module tb_lsu;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic [31:0] alu = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rd_data;

  lsu_if #(.XLEN(32)) dram_bus ();

  lsu #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .lsu_rd_en_i   (rd_en),
    .lsu_wr_en_i   (wr_en),
    .lsu_sel_i     (sel),
    .alu_data_i    (alu),
    .rs2_rd_data_i (rs2),
    .lsu_stall_o   (stall),
    .lsu_done_o    (done),
    .lsu_err_o     (err),
    .lsu_rd_data_o (rd_data),
    .dram          (dram_bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // expected transaction currently in flight
  bit          in_op = 1'b0;
  int          op_s = 0;
  int          op_done = 0;
  int          op_req_end = 0;
  bit          op_load = 1'b0;
  bit          op_err = 1'b0;
  bit          op_we = 1'b0;
  logic [31:0] op_addr = 32'h0;
  logic [3:0]  op_be = 4'h0;
  logic [31:0] op_wd = 32'h0;
  logic [31:0] op_rd = 32'h0;
  logic [31:0] model_rd = 32'h0;

  logic [31:0] last_addr = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0;
  int          last_done_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] s);
    if (s[1:0] == 2'd0) return 1;
    if (s[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit st, input logic [2:0] s, input logic [1:0] off);
    bit legal;
    if (st) legal = (s == 3'd0) || (s == 3'd1) || (s == 3'd2);
    else    legal = (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd4) || (s == 3'd5);
    if (!legal) return 1'b1;
    return (int'(off) % sz(s)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] s, input logic [1:0] off);
    logic [3:0] b;
    if (!st) return 4'hF;
    b = 4'h0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + sz(s)) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz(s)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] s, input logic [1:0] off, input logic [31:0] rdat);
    logic [31:0] v;
    v = rdat >> (8 * int'(off));
    if (sz(s) == 1) begin
      v = v & 32'h0000_00FF;
      if (!s[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz(s) == 2) begin
      v = v & 32'h0000_FFFF;
      if (!s[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Per-cycle comparison of DUT outputs against the transaction model
  always @(negedge clk) begin
    bit act, xs, xr, xd, xe;
    act = in_op && (cyc >= op_s) && (cyc <= op_done);
    if (act && cyc == op_done && op_load && !op_err) model_rd = op_rd;
    xs = act && (cyc < op_done);
    xr = act && (cyc > op_s) && (cyc <= op_req_end);
    xd = act && (cyc == op_done);
    xe = xd && op_err;
    chk("stall", 32'(stall), 32'(xs));
    chk("req", 32'(dram_bus.dram_req_o), 32'(xr));
    chk("done", 32'(done), 32'(xd));
    chk("err", 32'(err), 32'(xe));
    chk("rd_data", rd_data, model_rd);
    if (xr) begin
      chk("addr", dram_bus.dram_addr_o, op_addr);
      chk("be", 32'(dram_bus.dram_be_o), 32'(op_be));
      chk("we", 32'(dram_bus.dram_we_o), 32'(op_we));
      if (op_we) chk("wdata", dram_bus.dram_wr_data_o, op_wd);
      last_addr = dram_bus.dram_addr_o;
      last_be   = dram_bus.dram_be_o;
      last_wd   = dram_bus.dram_wr_data_o;
    end
    if (done) last_done_cyc = cyc;
  end

  // gdly < 0 means the bus never grants (timeout build only); rva = cycles from gnt to rvalid
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rdat, input int gdly, input int rva);
    bit st;
    int gc;
    int rc;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; sel = s; alu = a; rs2 = d;
    dram_bus.dram_gnt_i = 1'b0; dram_bus.dram_rvalid_i = 1'b0; dram_bus.dram_rd_data_i = rdat;
    st      = wr;
    op_s    = cyc;
    op_load = !st;
    op_we   = st;
    op_err  = m_err(st, s, a[1:0]);
    op_addr = {a[31:2], 2'b00};
    op_be   = m_be(st, s, a[1:0]);
    op_wd   = m_wd(s, d);
    op_rd   = m_ext(s, a[1:0], rdat);
    gc = -1;
    rc = -1;
    if (op_err) begin
      op_req_end = cyc;
      op_done    = cyc + 1;
    end else if (gdly < 0) begin
      op_req_end = cyc + TMO;
      op_done    = cyc + TMO + 1;
      op_err     = 1'b1;
    end else begin
      gc = cyc + 1 + gdly;
      op_req_end = gc;
      if (st) op_done = gc + 1;
      else begin
        rc = gc + rva;
        op_done = rc + 1;
      end
    end
    in_op = 1'b1;
    while (cyc < op_done) begin
      @(posedge clk); #1;
      dram_bus.dram_gnt_i    = (cyc == gc);
      dram_bus.dram_rvalid_i = (cyc == rc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      dram_bus.dram_gnt_i = 1'b0; dram_bus.dram_rvalid_i = 1'b0;
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    dram_bus.dram_gnt_i = 1'b0;
    dram_bus.dram_rvalid_i = 1'b0;
    dram_bus.dram_rd_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // model pinned by hand-computed values
    chk("pin_lb", m_ext(3'b000, 2'd2, 32'h12F45678), 32'hFFFFFFF4);
    chk("pin_lhu", m_ext(3'b101, 2'd2, 32'h12F45678), 32'h000012F4);
    chk("pin_sb_be", 32'(m_be(1'b1, 3'b000, 2'd3)), 32'h8);
    chk("pin_sb_wd", m_wd(3'b000, 32'h000000A5), 32'hA5A5A5A5);

    do_op(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
    settle();
    chk("sw_lat", 32'(last_done_cyc - op_s), 32'd2);
    chk("sw_addr", last_addr, 32'h104);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_wd", last_wd, 32'hDEADBEEF);

    do_op(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 0);
    settle();
    chk("sb_addr", last_addr, 32'h200);
    chk("sb_be", 32'(last_be), 32'h8);
    chk("sb_wd", last_wd, 32'hA5A5A5A5);

    do_op(1'b1, 1'b0, 3'b000, 32'h302, 32'h0, 32'h12F45678, 0, 1);
    settle();
    chk("lb_lit", rd_data, 32'hFFFFFFF4);
    chk("lb_lat", 32'(last_done_cyc - op_s), 32'd3);
    do_op(1'b1, 1'b0, 3'b100, 32'h302, 32'h0, 32'h12F45678, 0, 1);
    settle();
    chk("lbu_lit", rd_data, 32'h000000F4);
    do_op(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 32'h12F45678, 0, 1);
    settle();
    chk("lhu_lit", rd_data, 32'h000012F4);
    do_op(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 32'h00008001, 1, 1);
    do_op(1'b1, 1'b0, 3'b100, 32'h301, 32'h0, 32'h00008000, 0, 2);
    do_op(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 32'h00008001, 0, 1);
    settle();
    chk("lh_lit", rd_data, 32'hFFFF8001);

    do_op(1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 32'h11111111, 0, 1);
    settle();
    chk("misal_lat", 32'(last_done_cyc - op_s), 32'd1);
    chk("misal_rd", rd_data, 32'hFFFF8001);

    idle(1);
    do_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 3, 2);
    settle();
    chk("lw_dly_lat", 32'(last_done_cyc - op_s), 32'd7);
    chk("lw_dly_rd", rd_data, 32'hCAFEF00D);

    do_op(1'b0, 1'b1, 3'b001, 32'h402, 32'h1234BEEF, 32'h0, 2, 0);
    settle();
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wd", last_wd, 32'hBEEFBEEF);
    do_op(1'b0, 1'b1, 3'b100, 32'h0, 32'h1, 32'h0, 0, 0);
    do_op(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1);
    do_op(1'b1, 1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 0, 1);
    do_op(1'b0, 1'b1, 3'b001, 32'h3, 32'h0, 32'h0, 0, 0);
    do_op(1'b1, 1'b1, 3'b000, 32'h1, 32'h00000077, 32'h55555555, 0, 1);
    settle();
    chk("rdwr_be", 32'(last_be), 32'h2);
    chk("rdwr_rd", rd_data, 32'hCAFEF00D);
    idle(2);

    // reset during WAIT, then a late rvalid once back in IDLE
    @(posedge clk); #1;
    rd_en = 1'b1; wr_en = 1'b0; sel = 3'b010; alu = 32'h500;
    dram_bus.dram_rd_data_i = 32'h99999999;
    op_s = cyc; op_req_end = cyc + 1; op_done = cyc + 3; op_load = 1'b1; op_err = 1'b0;
    op_we = 1'b0; op_addr = 32'h500; op_be = 4'hF; op_rd = 32'h99999999; in_op = 1'b1;
    @(posedge clk); #1;
    dram_bus.dram_gnt_i = 1'b1;
    @(posedge clk); #1;
    dram_bus.dram_gnt_i = 1'b0;
    rst_n = 1'b0; in_op = 1'b0; model_rd = 32'h0; rd_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dram_bus.dram_rvalid_i = 1'b1;
    dram_bus.dram_gnt_i = 1'b1;
    @(posedge clk); #1;
    dram_bus.dram_rvalid_i = 1'b0;
    dram_bus.dram_gnt_i = 1'b0;
    idle(2);
    settle();
    chk("rst_rd", rd_data, 32'h0);

    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h13572468, 1, 1);
    settle();
    chk("post_rst_rd", rd_data, 32'h13572468);

`ifdef LSU_TIMEOUT_EN
    do_op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h0, -1, 0);
    settle();
    chk("tmo_lat", 32'(last_done_cyc - op_s), 32'(TMO + 1));
    chk("tmo_rd", rd_data, 32'h13572468);
`endif

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
